// File: rtl/run_detector.sv
// Mealy run-length detector: flags the beat completing RUN_LEN equal symbols; hit is 0-cycle comb, hit_q/run_cnt/last_sym/hit_count registered (1 cycle).
// No back-pressure: every valid beat is accepted.
module run_detector #(
  parameter int WIDTH   = 1,
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sym,
  input  logic             mode_overlap,
  output logic             hit,
  output logic             hit_q,
  output logic [CNT_W-1:0] run_cnt,
  output logic [WIDTH-1:0] last_sym,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DETECT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);

  state_t           state, state_nxt;
  logic             beat;
  logic             holding;
  logic             match;
  logic             hit_raw;
  logic [CNT_W-1:0] run_next;
  logic [CNT_W-1:0] run_cnt_nxt;
  logic [CNT_W-1:0] hit_count_nxt;
  logic [WIDTH-1:0] last_sym_nxt;

  assign beat     = in_valid & ~clr;
  assign holding  = (state == COUNT) || (state == DETECT);
  assign match    = (in_sym == last_sym);
  assign run_next = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;
  // Illegal state codes fall outside 'holding', so they can never produce a hit.
  assign hit_raw  = beat && holding && match && (run_next >= RUN_THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (beat) state_nxt = COUNT;
        end
        COUNT, DETECT: begin
          if (beat) begin
            if (hit_raw && mode_overlap) state_nxt = DETECT;
            else                         state_nxt = COUNT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    hit           = hit_raw;
    run_cnt_nxt   = run_cnt;
    last_sym_nxt  = last_sym;
    hit_count_nxt = hit_count;
    if (beat && (state == IDLE || (holding && !match))) begin
      run_cnt_nxt  = CNT_ONE;
      last_sym_nxt = in_sym;
    end else if (beat && holding) begin
      // Non-overlap restarts from zero so the next hit needs RUN_LEN fresh beats.
      run_cnt_nxt = (hit_raw && !mode_overlap) ? '0 : run_next;
    end
    if (hit_raw && hit_count != CNT_MAX) begin
      hit_count_nxt = hit_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q     <= 1'b0;
      run_cnt   <= '0;
      last_sym  <= '0;
      hit_count <= '0;
    end else if (clr) begin
      hit_q     <= 1'b0;
      run_cnt   <= '0;
      last_sym  <= '0;
      hit_count <= '0;
    end else begin
      hit_q     <= hit;
      run_cnt   <= run_cnt_nxt;
      last_sym  <= last_sym_nxt;
      hit_count <= hit_count_nxt;
    end
  end

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: table-driven vectors on a RUN_LEN=3 instance plus hand sequences on a RUN_LEN=2, CNT_W=3 instance.
module tb_run_detector;

  logic       clk;
  logic       rst_n;
  logic       a_clr, a_vld, a_ovl;
  logic [3:0] a_sym;
  logic       a_hit, a_hit_q;
  logic [7:0] a_run, a_cnt;
  logic [3:0] a_last;
  logic       b_clr, b_vld, b_ovl;
  logic [3:0] b_sym;
  logic       b_hit, b_hit_q;
  logic [2:0] b_run, b_cnt;
  logic [3:0] b_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [3:0] sym;
    logic       ovl;
    logic       hit;
    logic [7:0] run;
    logic [3:0] last;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  run_detector #(.WIDTH(4), .RUN_LEN(3), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_vld), .in_sym(a_sym),
    .mode_overlap(a_ovl), .hit(a_hit), .hit_q(a_hit_q), .run_cnt(a_run),
    .last_sym(a_last), .hit_count(a_cnt)
  );

  run_detector #(.WIDTH(4), .RUN_LEN(2), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_vld), .in_sym(b_sym),
    .mode_overlap(b_ovl), .hit(b_hit), .hit_q(b_hit_q), .run_cnt(b_run),
    .last_sym(b_last), .hit_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic clr, input logic vld, input logic [3:0] sym, input logic ovl,
                     input logic hit, input logic [7:0] run, input logic [3:0] last,
                     input logic [7:0] cnt);
    vec_t v;
    v.clr = clr; v.vld = vld; v.sym = sym; v.ovl = ovl;
    v.hit = hit; v.run = run; v.last = last; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Entered and left at posedge+1: hit sampled on the negedge, registers after the edge.
  task automatic apply_b(input string name, input logic clr, input logic vld, input logic [3:0] sym,
                         input logic ovl, input logic hit, input logic [2:0] run,
                         input logic [3:0] last, input logic [2:0] cnt);
    b_clr = clr; b_vld = vld; b_sym = sym; b_ovl = ovl;
    @(negedge clk);
    chk({name, " hit"}, b_hit, hit);
    @(posedge clk); #1;
    chk({name, " hit_q"}, b_hit_q, hit);
    chk({name, " run_cnt"}, b_run, run);
    chk({name, " last_sym"}, b_last, last);
    chk({name, " hit_count"}, b_cnt, cnt);
    b_clr = 1'b0; b_vld = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_clr = 1'b0; a_vld = 1'b1; a_sym = 4'h3; a_ovl = 1'b1;
    b_clr = 1'b0; b_vld = 1'b1; b_sym = 4'h3; b_ovl = 1'b1;
    #12;
    chk("reset a hit", a_hit, 0);
    chk("reset a hit_q", a_hit_q, 0);
    chk("reset a run_cnt", a_run, 0);
    chk("reset a last_sym", a_last, 0);
    chk("reset a hit_count", a_cnt, 0);
    chk("reset b hit", b_hit, 0);
    a_vld = 1'b0; b_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Overlap run of 0xA
    add(0, 1, 4'hA, 1, 0, 1, 4'hA, 0);
    add(0, 1, 4'hA, 1, 0, 2, 4'hA, 0);
    add(0, 1, 4'hA, 1, 1, 3, 4'hA, 1);
    add(0, 1, 4'hA, 1, 1, 4, 4'hA, 2);
    add(0, 1, 4'hA, 1, 1, 5, 4'hA, 3);
    add(1, 0, 4'h0, 1, 0, 0, 4'h0, 0);
    // Non-overlap run of 0xA
    add(0, 1, 4'hA, 0, 0, 1, 4'hA, 0);
    add(0, 1, 4'hA, 0, 0, 2, 4'hA, 0);
    add(0, 1, 4'hA, 0, 1, 0, 4'hA, 1);
    add(0, 1, 4'hA, 0, 0, 1, 4'hA, 1);
    add(0, 1, 4'hA, 0, 0, 2, 4'hA, 1);
    add(0, 1, 4'hA, 0, 1, 0, 4'hA, 2);
    add(0, 1, 4'hA, 0, 0, 1, 4'hA, 2);
    add(0, 0, 4'hA, 0, 0, 1, 4'hA, 2);
    // New symbol, overlap into DETECT, then mode switch to non-overlap
    add(0, 1, 4'h5, 1, 0, 1, 4'h5, 2);
    add(0, 1, 4'h5, 1, 0, 2, 4'h5, 2);
    add(0, 1, 4'h5, 1, 1, 3, 4'h5, 3);
    add(0, 1, 4'h5, 1, 1, 4, 4'h5, 4);
    add(0, 1, 4'h5, 0, 1, 0, 4'h5, 5);
    add(0, 1, 4'h5, 0, 0, 1, 4'h5, 5);
    add(0, 1, 4'h5, 1, 0, 2, 4'h5, 5);
    add(0, 1, 4'h5, 1, 1, 3, 4'h5, 6);
    add(0, 1, 4'hC, 1, 0, 1, 4'hC, 6);

    foreach (tbl[i]) begin
      a_clr = tbl[i].clr; a_vld = tbl[i].vld; a_sym = tbl[i].sym; a_ovl = tbl[i].ovl;
      @(negedge clk);
      chk($sformatf("vec%0d hit", i), a_hit, tbl[i].hit);
      @(posedge clk); #1;
      chk($sformatf("vec%0d hit_q", i), a_hit_q, tbl[i].hit);
      chk($sformatf("vec%0d run_cnt", i), a_run, tbl[i].run);
      chk($sformatf("vec%0d last_sym", i), a_last, tbl[i].last);
      chk($sformatf("vec%0d hit_count", i), a_cnt, tbl[i].cnt);
    end
    a_clr = 1'b0; a_vld = 1'b0;

    // Single-bit equivalence: 0,0,0,1,1,0
    apply_b("eq1", 0, 1, 4'h0, 1, 0, 1, 4'h0, 0);
    apply_b("eq2", 0, 1, 4'h0, 1, 1, 2, 4'h0, 1);
    apply_b("eq3", 0, 1, 4'h0, 1, 1, 3, 4'h0, 2);
    apply_b("eq4", 0, 1, 4'h1, 1, 0, 1, 4'h1, 2);
    apply_b("eq5", 0, 1, 4'h1, 1, 1, 2, 4'h1, 3);
    apply_b("eq6", 0, 1, 4'h0, 1, 0, 1, 4'h0, 3);

    // Idle cycles do not break a run
    apply_b("gap clr", 1, 0, 4'h0, 1, 0, 0, 4'h0, 0);
    apply_b("gap b1", 0, 1, 4'h5, 1, 0, 1, 4'h5, 0);
    apply_b("gap idle1", 0, 0, 4'h9, 1, 0, 1, 4'h5, 0);
    apply_b("gap idle2", 0, 0, 4'h5, 1, 0, 1, 4'h5, 0);
    apply_b("gap b2", 0, 1, 4'h5, 1, 1, 2, 4'h5, 1);

    // clr alongside a matching beat drops the beat
    apply_b("clr clr", 1, 0, 4'h0, 1, 0, 0, 4'h0, 0);
    apply_b("clr b1", 0, 1, 4'h7, 1, 0, 1, 4'h7, 0);
    apply_b("clr b2", 0, 1, 4'h7, 1, 1, 2, 4'h7, 1);
    apply_b("clr b3", 0, 1, 4'h7, 1, 1, 3, 4'h7, 2);
    apply_b("clr beat", 1, 1, 4'h7, 1, 0, 0, 4'h0, 0);
    apply_b("clr after", 0, 1, 4'h7, 1, 0, 1, 4'h7, 0);

    // Saturation of run_cnt and hit_count at 7
    apply_b("sat clr", 1, 0, 4'h0, 1, 0, 0, 4'h0, 0);
    for (int i = 1; i <= 12; i++) begin
      apply_b($sformatf("sat%0d", i), 0, 1, 4'h3, 1, (i >= 2),
              3'((i > 7) ? 7 : i), 4'h3, 3'((i - 1 > 7) ? 7 : i - 1));
    end

    // Async reset mid-stream clears immediately, then first beat acts from IDLE
    b_vld = 1'b1; b_sym = 4'h3; b_ovl = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst hit", b_hit, 0);
    chk("arst hit_q", b_hit_q, 0);
    chk("arst run_cnt", b_run, 0);
    chk("arst last_sym", b_last, 0);
    chk("arst hit_count", b_cnt, 0);
    chk("arst a hit_count", a_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_b("post rst", 0, 1, 4'h3, 1, 0, 1, 4'h3, 0);
    apply_b("post rst2", 0, 1, 4'h3, 1, 1, 2, 4'h3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
